// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, taken-branch and fetch-wait stall/flush control
// for the 5-stage core, with saturating stall and flush counters.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   id_rs, id_rt        source registers of the ID instruction
//   id_uses_rt          ID instruction reads id_rt
//   ex_rd               destination register of the EX instruction
//   ex_mem_read         EX instruction is a load
//   ex_branch_taken     EX branch/jump resolved taken
//   imem_ready          fetched word at PC is valid this cycle
//   pc_enable           PC loads its next value
//   ifid_enable         IF/ID buffer enable
//   ifid_flush          IF/ID captures a NOP
//   idex_flush          ID/EX captures a bubble
//   stall_cnt           saturating count of cycles with pc_enable=0
//   flush_cnt           saturating count of honoured taken branches
module hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN,
    LD_STALL,
    FETCH_WAIT
  } state_t;

  localparam logic [2:0] RELOAD = 3'(STALL_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [2:0] rem;
  logic [2:0] rem_nx;
  logic       lu;
  logic       br_take;

  assign lu = ex_mem_read
           && (ex_rd != '0)
           && ((ex_rd == id_rs)
            || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    pc_enable   = 1'b0;
    ifid_enable = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    br_take     = 1'b0;
    state_nx    = state;
    rem_nx      = rem;

    case (state)
      RUN: begin
        if (ex_branch_taken) begin
          pc_enable   = 1'b1;
          ifid_enable = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          br_take     = 1'b1;
          state_nx    = RUN;
        end else if (lu) begin
          idex_flush = 1'b1;
          if (STALL_CYCLES == 1) begin
            state_nx = RUN;
          end else begin
            rem_nx   = RELOAD;
            state_nx = LD_STALL;
          end
        end else if (!imem_ready) begin
          ifid_enable = 1'b1;
          ifid_flush  = 1'b1;
          state_nx    = FETCH_WAIT;
        end else begin
          pc_enable   = 1'b1;
          ifid_enable = 1'b1;
          state_nx    = RUN;
        end
      end

      // EX holds a bubble here, so branch and fetch status are moot
      LD_STALL: begin
        idex_flush = 1'b1;
        rem_nx     = rem - 3'd1;
        if (rem == 3'd1) begin
          state_nx = RUN;
        end
      end

      // ID holds a NOP here, so no load-use check
      FETCH_WAIT: begin
        if (ex_branch_taken) begin
          pc_enable   = 1'b1;
          ifid_enable = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          br_take     = 1'b1;
          state_nx    = RUN;
        end else if (!imem_ready) begin
          ifid_enable = 1'b1;
          ifid_flush  = 1'b1;
          state_nx    = FETCH_WAIT;
        end else begin
          pc_enable   = 1'b1;
          ifid_enable = 1'b1;
          state_nx    = RUN;
        end
      end

      default: begin
        state_nx = RUN;
        rem_nx   = '0;
      end
    endcase

    // Outputs are forced low for the whole reset interval
    if (reset) begin
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      br_take     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      rem   <= '0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_enable && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (br_take && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed table and sequence checks of hazard_ctrl
// across three parameterisations sharing one stimulus bus.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_branch_taken;
  logic       imem_ready;

  logic        pe1, ie1, if1, xf1;
  logic [3:0]  sc1, fc1;
  logic        pe3, ie3, if3, xf3;
  logic [15:0] sc3, fc3;
  logic        pe4, ie4, if4, xf4;
  logic [15:0] sc4, fc4;

  logic [3:0] o1, o3, o4;
  assign o1 = {pe1, ie1, if1, xf1};
  assign o3 = {pe3, ie3, if3, xf3};
  assign o4 = {pe4, ie4, if4, xf4};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .STALL_CYCLES(1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
    .pc_enable(pe1), .ifid_enable(ie1),
    .ifid_flush(if1), .idex_flush(xf1),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  hazard_ctrl #(.REG_W(5), .STALL_CYCLES(3), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
    .pc_enable(pe3), .ifid_enable(ie3),
    .ifid_flush(if3), .idex_flush(xf3),
    .stall_cnt(sc3), .flush_cnt(fc3)
  );

  hazard_ctrl #(.REG_W(5), .STALL_CYCLES(4), .CNT_W(16)) u4 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
    .pc_enable(pe4), .ifid_enable(ie4),
    .ifid_flush(if4), .idex_flush(xf4),
    .stall_cnt(sc4), .flush_cnt(fc4)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       rdy;
    logic [3:0] exp;
    int         exp_stall;
    int         exp_flush;
  } vec_t;

  vec_t vt[14];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses, input logic [4:0] rd,
                       input logic mr, input logic br, input logic rdy);
    id_rs = rs;
    id_rt = rt;
    id_uses_rt = uses;
    ex_rd = rd;
    ex_mem_read = mr;
    ex_branch_taken = br;
    imem_ready = rdy;
  endtask

  // apply inputs at negedge, settle before the next posedge
  task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                      input logic uses, input logic [4:0] rd,
                      input logic mr, input logic br, input logic rdy);
    @(negedge clk);
    drive(rs, rt, uses, rd, mr, br, rdy);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    #2;
    check("reset_out_u1", int'(o1), 0);
    check("reset_out_u3", int'(o3), 0);
    check("reset_out_u4", int'(o4), 0);
    check("reset_cnt_u3", int'(sc3) + int'(fc3), 0);

    // STALL_CYCLES=3 table, sequential from reset
    vt[0]  = '{5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 4'b1100, 0, 0};
    vt[1]  = '{5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 4'b0001, 0, 0};
    vt[2]  = '{5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 4'b0001, 1, 0};
    vt[3]  = '{5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 4'b0001, 2, 0};
    vt[4]  = '{5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 4'b1100, 3, 0};
    vt[5]  = '{5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 4'b1100, 3, 0};
    vt[6]  = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 4'b1100, 3, 0};
    vt[7]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 4'b1111, 3, 0};
    vt[8]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0001, 3, 1};
    vt[9]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0001, 4, 1};
    vt[10] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0001, 5, 1};
    vt[11] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 4'b0110, 6, 1};
    vt[12] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0110, 7, 1};
    vt[13] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 4'b1100, 8, 1};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(vt[i].rs, vt[i].rt, vt[i].uses, vt[i].rd,
           vt[i].mr, vt[i].br, vt[i].rdy);
      check($sformatf("vec%0d_out", i), int'(o3), int'(vt[i].exp));
      check($sformatf("vec%0d_stall", i), int'(sc3), vt[i].exp_stall);
      check($sformatf("vec%0d_flush", i), int'(fc3), vt[i].exp_flush);
    end

    // STALL_CYCLES=1: single bubble, then saturation at CNT_W=4
    do_reset();
    step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
    check("s1_stall_out", int'(o1), 4'b0001);
    step(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1);
    check("s1_resume_out", int'(o1), 4'b1100);
    check("s1_stall_cnt", int'(sc1), 1);
    for (int i = 0; i < 20; i++) begin
      step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      if (i == 0) check("s1_wait_out", int'(o1), 4'b0110);
    end
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("s1_sat_cnt", int'(sc1), 15);
    check("s1_sat_out", int'(o1), 4'b1100);

    // fetch wait: three empty cycles, then a branch mid-wait
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      check($sformatf("fw_wait%0d", i), int'(o3), 4'b0110);
    end
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("fw_done", int'(o3), 4'b1100);
    check("fw_stall_cnt", int'(sc3), 3);
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("fw2_wait", int'(o3), 4'b0110);
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("fw2_branch", int'(o3), 4'b1111);
    // back in RUN, so a load-use now stalls
    step(5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
    check("fw2_run_lu", int'(o3), 4'b0001);
    check("fw2_flush_cnt", int'(fc3), 1);

    // STALL_CYCLES=4: async reset in the 2nd stall cycle
    do_reset();
    step(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    check("s4_stall1", int'(o4), 4'b0001);
    step(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    check("s4_stall2", int'(o4), 4'b0001);
    check("s4_cnt_pre", int'(sc4), 1);
    #1 reset = 1'b1;
    #1;
    check("s4_rst_out", int'(o4), 0);
    check("s4_rst_cnt", int'(sc4), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    #2;
    check("s4_post0", int'(o4), 4'b1100);
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("s4_post1", int'(o4), 4'b1100);
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("s4_post2", int'(o4), 4'b1100);
    check("s4_post_cnt", int'(sc4), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core. It drives the PC write enable and the IF/ID buffer enable, and generates flush requests for IF/ID and ID/EX. It resolves load-use hazards with a programmable stall length, taken-branch redirects, and instruction-memory wait cycles. Saturating performance counters record stall cycles and branch flushes.

## Interface

Parameters:
- REG_W, 5, register-specifier width.
- STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal 1..7.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- id_rs  in  REG_W  source register 1 of the instruction in ID.
- id_rt  in  REG_W  source register 2 of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads id_rt.
- ex_rd  in  REG_W  destination register of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_branch_taken  in  1  branch or jump in EX resolved taken; PC mux selects the target.
- imem_ready  in  1  instruction word at the current PC is valid this cycle.
- pc_enable  out  1  PC register loads its next value.
- ifid_enable  out  1  drives the IF/ID buffer enable.
- ifid_flush  out  1  IF/ID input mux selects NOP (32'h0) instead of the fetched word.
- idex_flush  out  1  ID/EX captures a bubble (all control bits 0).
- stall_cnt  out  CNT_W  cycles with pc_enable=0 since reset; saturating.
- flush_cnt  out  CNT_W  taken-branch flushes since reset; saturating.

## Operation

- The FSM has three states: RUN, LD_STALL, FETCH_WAIT. The remaining-stall counter is 3 bits.
- Outputs are combinational from state and inputs. While reset is high, all outputs are 0, state is RUN, and the counters are 0.
- A load-use hazard (lu) is defined as: ex_mem_read AND ex_rd != 0 AND (ex_rd == id_rs OR (id_uses_rt AND ex_rd == id_rt)).
- RUN, evaluated in fixed priority order:
  - ex_branch_taken: pc_enable=1, ifid_enable=1, ifid_flush=1, idex_flush=1. flush_cnt increments. Next state RUN. imem_ready is ignored.
  - else lu: pc_enable=0, ifid_enable=0, idex_flush=1. If STALL_CYCLES==1, next state RUN; otherwise the remaining counter loads STALL_CYCLES-1 and next state is LD_STALL.
  - else !imem_ready: pc_enable=0, ifid_enable=1, ifid_flush=1. Next state FETCH_WAIT.
  - else: pc_enable=1, ifid_enable=1, no flush. Next state RUN.
- LD_STALL:
  - Outputs: pc_enable=0, ifid_enable=0, idex_flush=1.
  - The remaining counter decrements each cycle. When remaining==1, next state is RUN.
  - ex_branch_taken and imem_ready are ignored, because EX holds a bubble.
- FETCH_WAIT:
  - ex_branch_taken: same response as in RUN; next state RUN.
  - else !imem_ready: pc_enable=0, ifid_enable=1, ifid_flush=1; stay in FETCH_WAIT.
  - else: pc_enable=1, ifid_enable=1, no flush; next state RUN.
  - lu is not evaluated, since ID holds a NOP.
- Counters:
  - stall_cnt increments on every non-reset cycle with pc_enable=0.
  - flush_cnt increments on every cycle where a taken branch is honoured.
  - Both hold at 2^CNT_W-1.
- The ifid_flush and idex_flush outputs never assert while ifid_enable=0, with one exception: idex_flush during a load-use stall.

## Timing

- Hazard response has zero latency: outputs react in the same cycle as the inputs. State and counters update on the next edge.
- A load-use hazard holds the PC and IF/ID for exactly STALL_CYCLES cycles. The dependent instruction leaves ID on cycle STALL_CYCLES+1.
- A taken branch costs two flushed slots (IF/ID and ID/EX). The target is fetched in the cycle after the redirect.
- When a branch and lu occur in the same cycle, the branch wins and lu is discarded, because the ID instruction is flushed.
- When lu and !imem_ready occur in the same cycle, lu wins. The fetch is retried after the stall.
- Reset mid-stall or mid-wait returns to RUN immediately and asynchronously. There is no residual stall.
- After reset deasserts, the first edge is evaluated in RUN.

## Test plan

- STALL_CYCLES=1, ex_mem_read=1, ex_rd=5, id_rs=5 -> one cycle with pc_enable=0, ifid_enable=0, idex_flush=1; then normal operation; stall_cnt=1.
- STALL_CYCLES=3, same hazard via id_rt with id_uses_rt=1 -> three stall cycles (RUN, LD_STALL, LD_STALL), then RUN; with id_uses_rt=0 -> no stall; with ex_rd=0 -> no stall.
- ex_branch_taken=1 and lu in the same cycle -> ifid_flush=1, idex_flush=1, pc_enable=1; flush_cnt=1; state RUN.
- imem_ready=0 for 3 cycles, then 1 -> 3 cycles of pc_enable=0, ifid_flush=1, then pc_enable=1; a branch in the 2nd wait cycle -> redirect and exit to RUN.
- reset asserted during the 2nd cycle of a STALL_CYCLES=4 stall -> outputs and counters go to 0 immediately; after release, normal fetch with no further stall.
- CNT_W=4 with 20 consecutive stall cycles -> stall_cnt saturates at 15.
